// File: rtl/div16_pkg.sv
// Shared types and constants for the sequential 16-bit restoring divider.
package div16_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported for a zero divisor.
    localparam logic [DEF_WIDTH-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/div16_seq_sub17.sv
// Ripple subtractor a - b built from half/full adder cells: b inverted, carry-in 1.
module div16_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module div16_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0, c0, c1;

    div16_ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    div16_ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

module sub17 #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        div16_fa u_fa (.a(a[i]), .b(~b[i]), .ci(c[i]), .s(diff[i]), .co(c[i+1]));
    end

    assign borrow = ~c[N];
endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock,
// start/ready handshake with a one-cycle done pulse.
module div16_seq
    import div16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, d, r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   t, diff;
    logic [WIDTH-1:0] q_nxt, r_nxt;
    logic             borrow, take, accept, last, dz_req;

    assign accept = start & ready;
    assign dz_req = (divisor == '0);
    assign last   = (cnt == '0);

    // Partial remainder always stays below D, so W bits hold it between steps.
    assign t = {r, q[WIDTH-1]};

    sub17 #(.N(WIDTH+1)) u_sub (
        .a      (t),
        .b      ({1'b0, d}),
        .diff   (diff),
        .borrow (borrow)
    );

    // On no-borrow diff < D, so its top bit is zero; folding it in keeps r_nxt exact.
    assign take  = ~borrow & ~diff[WIDTH];
    assign r_nxt = take ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_nxt = {q[WIDTH-2:0], take};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = dz_req ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            RUN:     if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q           <= '0;
            d           <= '0;
            r           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (!dz_req) begin
                q   <= dividend;
                d   <= divisor;
                r   <= '0;
                cnt <= CNT_W'(WIDTH-1);
            end else begin
                quotient    <= WIDTH'(DZ_QUOT);
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (busy) begin
            q <= q_nxt;
            r <= r_nxt;
            if (last) begin
                quotient    <= q_nxt;
                remainder   <= r_nxt;
                div_by_zero <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// Randomized and directed checks of div16_seq against a countdown/arithmetic model.
module tb_div16_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad = 0;

    div16_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_left = -1 idle, >0 cycles of work left, 0 = the done cycle.
    int           m_left = -1;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_dz = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = -1;
            m_q = '0;
            m_r = '0;
            m_dz = 1'b0;
        end else if (m_left <= 0 && start) begin
            if (divisor == 0) begin
                m_left = 0;
                m_q = 16'hFFFF;
                m_r = dividend;
                m_dz = 1'b1;
            end else begin
                m_left = W;
                p_q = dividend / divisor;
                p_r = dividend % divisor;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_q = p_q;
                m_r = p_r;
                m_dz = 1'b0;
            end
        end else begin
            m_left = -1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("ready", ready, m_left <= 0);
            chk("busy", busy, m_left > 0);
            chk("done", done, m_left == 0);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", div_by_zero, m_dz);
        end
    end

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat, input string nm);
        int lat;
        @(negedge clk);
        for (int k = 0; k < 40 && !ready; k++) @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
        wait_done(1, lat);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dz"}, div_by_zero, edz);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_model_q"}, m_q, eq);
        chk({nm, "_model_r"}, m_r, er);
    endtask

    initial begin
        int lat;
        int seen;
        int sel;

        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        reset = 1'b0;

        do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, "t100_7");
        do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, "tffff_1");
        do_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, "t3_10");
        do_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, "tdz");

        // Start arriving mid-operation must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd33;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 16'd9; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat);
        chk("ign_lat", lat, 17);
        chk("ign_q", quotient, 16'd30);
        chk("ign_r", remainder, 16'd10);

        // Asynchronous reset mid-run aborts with no done.
        @(negedge clk);
        start = 1'b1; dividend = 16'd50000; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dz", div_by_zero, 0);
        chk("arst_ready", ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("arst_no_done", seen, 0);
        do_op(16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 17, "t7_7");

        // start held high through DONE: next operation begins with no idle gap.
        @(negedge clk);
        start = 1'b1; dividend = 16'd65535; divisor = 16'd256;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 40) begin
            dividend = W'($urandom);
            divisor = W'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("b2b1_lat", lat, 17);
        chk("b2b1_q", quotient, 16'd255);
        chk("b2b1_r", remainder, 16'd255);
        dividend = 16'd200; divisor = 16'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat);
        chk("b2b2_lat", lat, 17);
        chk("b2b2_q", quotient, 16'd22);
        chk("b2b2_r", remainder, 16'd2);

        // Random operations, spurious starts while busy, random gaps.
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = $urandom_range(0, 7);
            dividend = W'($urandom);
            divisor = (sel == 0) ? 16'd0 : (sel < 4) ? W'($urandom_range(1, 15)) : W'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 40 && !ready; k++) begin
                start = ($urandom_range(0, 3) == 0);
                dividend = W'($urandom);
                divisor = W'($urandom);
                @(negedge clk);
            end
            if (!ready) chk("rand_timeout", 0, 1);
            start = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
